liteic_axil_regfile_slave: RTL and testbench



---
 rtl/liteic_axil_regfile_slave_pkg.sv | 42 ++++
 rtl/liteic_axil_regfile_slave_if.sv | 32 +++
 rtl/liteic_axil_regfile_slave_core.sv | 63 ++++++
 rtl/liteic_axil_regfile_slave.sv | 204 ++++++++++++++++++++
 tb/tb_liteic_axil_regfile_slave.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/liteic_axil_regfile_slave_pkg.sv
// Shared AXI-Lite widths, response codes, channel FSM states and the byte-strobe merge helper
// used by the register-file slave slice.
package liteic_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH = 32;
    localparam int unsigned AXI_RESP_WIDTH = 2;
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef logic [AXI_RESP_WIDTH-1:0] axil_resp_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    function automatic logic [AXI_DATA_WIDTH-1:0] strb_merge(
        input logic [AXI_DATA_WIDTH-1:0] old_val,
        input logic [AXI_DATA_WIDTH-1:0] new_val,
        input logic [AXI_STRB_WIDTH-1:0] strb
    );
        logic [AXI_DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(AXI_STRB_WIDTH); b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/liteic_axil_regfile_slave_if.sv
// AXI-Lite bundle (AR/R/AW/W/B) with initiator (mp) and responder (sp) views.
interface axi_lite_if;

    logic                                  ar_valid;
    logic                                  ar_ready;
    logic [liteic_pkg::AXI_ADDR_WIDTH-1:0] ar_addr;
    logic                                  r_valid;
    logic                                  r_ready;
    logic [liteic_pkg::AXI_DATA_WIDTH-1:0] r_data;
    logic [liteic_pkg::AXI_RESP_WIDTH-1:0] r_resp;
    logic                                  aw_valid;
    logic                                  aw_ready;
    logic [liteic_pkg::AXI_ADDR_WIDTH-1:0] aw_addr;
    logic                                  w_valid;
    logic                                  w_ready;
    logic [liteic_pkg::AXI_DATA_WIDTH-1:0] w_data;
    logic [liteic_pkg::AXI_STRB_WIDTH-1:0] w_strb;
    logic                                  b_valid;
    logic                                  b_ready;
    logic [liteic_pkg::AXI_RESP_WIDTH-1:0] b_resp;

    modport mp (
        output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
        input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
    );

    modport sp (
        input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
        output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
    );

endinterface

// File: rtl/liteic_axil_regfile_slave_core.sv
// Register storage: byte-strobe writes, read-only slots mirrored from status_i, one-cycle commit strobes.
module liteic_regfile_core
    import liteic_pkg::*;
#(
    parameter int unsigned        REG_NUM = 16,
    parameter int unsigned        IDX_W   = 4,
    parameter logic [REG_NUM-1:0] RO_MASK = '0
) (
    input  logic                                    clk_i,
    input  logic                                    rstn_i,
    input  logic                                    wr_en,
    input  logic [IDX_W-1:0]                        wr_idx,
    input  logic [AXI_DATA_WIDTH-1:0]               wr_data,
    input  logic [AXI_STRB_WIDTH-1:0]               wr_strb,
    input  logic [IDX_W-1:0]                        rd_idx,
    output logic [AXI_DATA_WIDTH-1:0]               rd_data,
    input  logic [REG_NUM-1:0][AXI_DATA_WIDTH-1:0]  status_i,
    output logic [REG_NUM-1:0][AXI_DATA_WIDTH-1:0]  ctrl_o,
    output logic [REG_NUM-1:0]                      wr_pulse_o
);

    localparam logic [IDX_W:0] REG_COUNT = (IDX_W+1)'(REG_NUM);

    logic [REG_NUM-1:0][AXI_DATA_WIDTH-1:0] regs_r;
    logic [REG_NUM-1:0]                     pulse_r;
    logic [AXI_DATA_WIDTH-1:0]              rd_data_s;

    // Storage update and commit strobe; read-only slots keep their reset value of zero
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            regs_r  <= '0;
            pulse_r <= '0;
        end else begin
            for (int k = 0; k < int'(REG_NUM); k++) begin
                if (wr_en && !RO_MASK[k] && (wr_idx == IDX_W'(k))) begin
                    regs_r[k]  <= strb_merge(regs_r[k], wr_data, wr_strb);
                    pulse_r[k] <= 1'b1;
                end else begin
                    pulse_r[k] <= 1'b0;
                end
            end
        end
    end

    // Read mux: read-only slots return the live status value
    always_comb begin
        rd_data_s = '0;
        if ({1'b0, rd_idx} < REG_COUNT) begin
            if (RO_MASK[rd_idx]) begin
                rd_data_s = status_i[rd_idx];
            end else begin
                rd_data_s = regs_r[rd_idx];
            end
        end else begin
            rd_data_s = '0;
        end
    end

    assign rd_data    = rd_data_s;
    assign ctrl_o     = regs_r;
    assign wr_pulse_o = pulse_r;

endmodule

// File: rtl/liteic_axil_regfile_slave.sv
// AXI-Lite responder for one interconnect slot: address decode plus independent read and
// write channel FSMs in front of the register-file core.
module liteic_axil_regfile_slave
    import liteic_pkg::*;
#(
    parameter int unsigned                REG_NUM   = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR = 32'h0000_0000,
    parameter logic [REG_NUM-1:0]         RO_MASK   = '0
) (
    input  logic                                    clk_i,
    input  logic                                    rstn_i,
    axi_lite_if.sp                                  slv_axil,
    output logic [REG_NUM-1:0][AXI_DATA_WIDTH-1:0]  ctrl_o,
    input  logic [REG_NUM-1:0][AXI_DATA_WIDTH-1:0]  status_i,
    output logic [REG_NUM-1:0]                      wr_pulse_o
);

    localparam int unsigned              IDX_W      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [AXI_ADDR_WIDTH:0]  ADDR_LIMIT = (AXI_ADDR_WIDTH+1)'(4 * REG_NUM);

    generate
        if ((BASE_ADDR[1:0] != 2'b00) || (REG_NUM < 1)) begin : g_param_check
            $error("liteic_axil_regfile_slave: BASE_ADDR must be word aligned and REG_NUM >= 1");
        end
    endgenerate

    // Returns {hit, register index}
    function automatic logic [IDX_W:0] decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] off;
        logic                      hit;
        off = addr - BASE_ADDR;
        hit = (addr >= BASE_ADDR) && ({1'b0, off} < ADDR_LIMIT) && (addr[1:0] == 2'b00);
        return {hit, off[IDX_W+1:2]};
    endfunction

    rd_state_e                  rd_state_r, rd_state_s;
    logic                       ar_hs_s, ar_hit_s;
    logic [IDX_W-1:0]           rd_idx_s;
    logic [AXI_DATA_WIDTH-1:0]  rd_data_s, r_data_r;
    axil_resp_t                 r_resp_r;

    wr_state_e                  wr_state_r, wr_state_s;
    logic                       aw_held_r, w_held_r;
    logic [AXI_ADDR_WIDTH-1:0]  aw_addr_r, aw_addr_s;
    logic [AXI_DATA_WIDTH-1:0]  w_data_r, w_data_s;
    logic [AXI_STRB_WIDTH-1:0]  w_strb_r, w_strb_s;
    logic                       aw_ready_s, w_ready_s, aw_hs_s, w_hs_s, commit_s;
    logic                       wr_hit_s, wr_ok_s;
    logic [IDX_W-1:0]           wr_idx_s;
    axil_resp_t                 b_resp_r;

    assign ar_hs_s              = slv_axil.ar_valid && (rd_state_r == R_IDLE);
    assign {ar_hit_s, rd_idx_s} = decode(slv_axil.ar_addr);

    // Read next state
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_s = R_RESP;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_RESP: begin
                if (slv_axil.r_ready) begin
                    rd_state_s = R_IDLE;
                end else begin
                    rd_state_s = R_RESP;
                end
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Read state register and response capture (data sampled before any same-edge write)
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_state_r <= R_IDLE;
            r_data_r   <= '0;
            r_resp_r   <= RESP_OKAY;
        end else begin
            rd_state_r <= rd_state_s;
            if (ar_hs_s) begin
                if (ar_hit_s) begin
                    r_data_r <= rd_data_s;
                    r_resp_r <= RESP_OKAY;
                end else begin
                    r_data_r <= '0;
                    r_resp_r <= RESP_SLVERR;
                end
            end
        end
    end

    assign aw_ready_s = (wr_state_r == W_IDLE) && !aw_held_r;
    assign w_ready_s  = (wr_state_r == W_IDLE) && !w_held_r;
    assign aw_hs_s    = slv_axil.aw_valid && aw_ready_s;
    assign w_hs_s     = slv_axil.w_valid && w_ready_s;
    assign commit_s   = (wr_state_r == W_IDLE) && (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);

    // Effective write address/data: held copy if already accepted, else the live bus
    always_comb begin
        aw_addr_s = slv_axil.aw_addr;
        w_data_s  = slv_axil.w_data;
        w_strb_s  = slv_axil.w_strb;
        if (aw_held_r) begin
            aw_addr_s = aw_addr_r;
        end else begin
            aw_addr_s = slv_axil.aw_addr;
        end
        if (w_held_r) begin
            w_data_s = w_data_r;
            w_strb_s = w_strb_r;
        end else begin
            w_data_s = slv_axil.w_data;
            w_strb_s = slv_axil.w_strb;
        end
    end

    assign {wr_hit_s, wr_idx_s} = decode(aw_addr_s);
    assign wr_ok_s              = wr_hit_s && !RO_MASK[wr_idx_s];

    // Write next state
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (commit_s) begin
                    wr_state_s = W_RESP;
                end else begin
                    wr_state_s = W_IDLE;
                end
            end
            W_RESP: begin
                if (slv_axil.b_ready) begin
                    wr_state_s = W_IDLE;
                end else begin
                    wr_state_s = W_RESP;
                end
            end
            default: wr_state_s = W_IDLE;
        endcase
    end

    // Write state register, AW/W hold registers and B response
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_state_r <= W_IDLE;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            aw_addr_r  <= '0;
            w_data_r   <= '0;
            w_strb_r   <= '0;
            b_resp_r   <= RESP_OKAY;
        end else begin
            wr_state_r <= wr_state_s;
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                b_resp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs_s) begin
                    aw_held_r <= 1'b1;
                    aw_addr_r <= slv_axil.aw_addr;
                end
                if (w_hs_s) begin
                    w_held_r <= 1'b1;
                    w_data_r <= slv_axil.w_data;
                    w_strb_r <= slv_axil.w_strb;
                end
            end
        end
    end

    assign slv_axil.ar_ready = (rd_state_r == R_IDLE);
    assign slv_axil.r_valid  = (rd_state_r == R_RESP);
    assign slv_axil.r_data   = r_data_r;
    assign slv_axil.r_resp   = r_resp_r;
    assign slv_axil.aw_ready = aw_ready_s;
    assign slv_axil.w_ready  = w_ready_s;
    assign slv_axil.b_valid  = (wr_state_r == W_RESP);
    assign slv_axil.b_resp   = b_resp_r;

    liteic_regfile_core #(
        .REG_NUM (REG_NUM),
        .IDX_W   (IDX_W),
        .RO_MASK (RO_MASK)
    ) u_core (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .wr_en      (commit_s && wr_ok_s),
        .wr_idx     (wr_idx_s),
        .wr_data    (w_data_s),
        .wr_strb    (w_strb_s),
        .rd_idx     (rd_idx_s),
        .rd_data    (rd_data_s),
        .status_i   (status_i),
        .ctrl_o     (ctrl_o),
        .wr_pulse_o (wr_pulse_o)
    );

endmodule

// File: tb/tb_liteic_axil_regfile_slave.sv
// Directed plus randomized bench for liteic_axil_regfile_slave against an array-based register model.
module tb_liteic_axil_regfile_slave;

    logic                clk;
    logic                rstn;
    logic [15:0][31:0]   ctrl;
    logic [15:0][31:0]   status;
    logic [15:0]         wr_pulse;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [16];

    axi_lite_if bus ();

    liteic_axil_regfile_slave #(
        .REG_NUM   (16),
        .BASE_ADDR (32'h0000_0000),
        .RO_MASK   (16'h8000)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .slv_axil   (bus),
        .ctrl_o     (ctrl),
        .status_i   (status),
        .wr_pulse_o (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s_ctrl%0d", tag, k), {32'h0, ctrl[k]}, {32'h0, mdl[k]});
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) mask = mask | (32'hFF << (8 * b));
        end
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int lat, output logic [15:0] pulse_b,
                             output logic [15:0] pulse_after, output logic glitch, output logic idle_after);
        int cyc;
        bit aw_done, w_done, aw_fire, w_fire;
        cyc = 0; aw_done = 0; w_done = 0; glitch = 1'b0; lat = 0;
        bus.aw_addr = addr; bus.w_data = data; bus.w_strb = strb;
        while (!(aw_done && w_done) && cyc < 60) begin
            if (!aw_done && cyc >= aw_dly) bus.aw_valid = 1'b1;
            if (!w_done && cyc >= w_dly) bus.w_valid = 1'b1;
            if (aw_done && bus.aw_ready) glitch = 1'b1;
            if (w_done && bus.w_ready) glitch = 1'b1;
            if (bus.b_valid) glitch = 1'b1;
            aw_fire = bus.aw_valid && bus.aw_ready;
            w_fire  = bus.w_valid && bus.w_ready;
            @(posedge clk); #1;
            if (aw_fire) begin bus.aw_valid = 1'b0; aw_done = 1; end
            if (w_fire) begin bus.w_valid = 1'b0; w_done = 1; end
            cyc++;
        end
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        while (!bus.b_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        resp = bus.b_resp;
        pulse_b = wr_pulse;
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
        pulse_after = wr_pulse;
        idle_after = bus.aw_ready && bus.w_ready && !bus.b_valid;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rdly,
                            output logic [31:0] data, output logic [1:0] resp, output int lat,
                            output logic stable);
        int cyc;
        cyc = 0; lat = 0; stable = 1'b1;
        bus.ar_addr = addr;
        bus.ar_valid = 1'b1;
        while (!bus.ar_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        while (!bus.r_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        data = bus.r_data;
        resp = bus.r_resp;
        if (bus.ar_ready) stable = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            @(posedge clk); #1;
            if (!bus.r_valid || bus.r_data !== data || bus.r_resp !== resp || bus.ar_ready) stable = 1'b0;
        end
        bus.r_ready = 1'b1;
        @(posedge clk); #1;
        bus.r_ready = 1'b0;
        if (bus.r_valid || !bus.ar_ready) stable = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata, addr, data;
        logic [15:0] pb, pa, exp_pulse;
        logic        glitch, stable, idle, hit, ro;
        logic [3:0]  strb;
        int          lat, idx, sel;

        rstn = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mdl[k] = 32'h0;
            status[k] = $urandom;
        end
        status[15] = 32'h0000_CAFE;
        bus.ar_valid = 1'b0; bus.ar_addr = 32'h0; bus.r_ready = 1'b0;
        bus.aw_valid = 1'b0; bus.aw_addr = 32'h0; bus.w_valid = 1'b0;
        bus.w_data = 32'h0; bus.w_strb = 4'h0; bus.b_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {61'h0, bus.ar_ready, bus.aw_ready, bus.w_ready}, {61'h0, 3'b111});
        chk("rst_valid", {62'h0, bus.r_valid, bus.b_valid}, 64'h0);
        chk("rst_resp_data", {28'h0, bus.r_resp, bus.b_resp, bus.r_data}, 64'h0);
        chk("rst_pulse", {48'h0, wr_pulse}, 64'h0);
        chk_ctrl("rst");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Step 1: same-cycle AW+W
        axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, resp, lat, pb, pa, glitch, idle);
        mdl[1] = 32'hDEAD_BEEF;
        chk("s1_bresp", {62'h0, resp}, 64'h0);
        chk("s1_blat", lat, 64'd0);
        chk("s1_pulse", {48'h0, pb}, {48'h0, 16'h0002});
        chk("s1_pulse_after", {48'h0, pa}, 64'h0);
        chk("s1_idle_after", {63'h0, idle}, 64'h1);
        chk_ctrl("s1");

        // Step 2: W three cycles ahead of AW, partial strobe
        axi_write(32'h08, 32'h1122_3344, 4'b0101, 3, 0, resp, lat, pb, pa, glitch, idle);
        mdl[2] = merge(32'h0, 32'h1122_3344, 4'b0101);
        chk("s2_bresp", {62'h0, resp}, 64'h0);
        chk("s2_blat", lat, 64'd0);
        chk("s2_no_early_ready", {63'h0, glitch}, 64'h0);
        chk("s2_reg2", {32'h0, ctrl[2]}, {32'h0, 32'h0022_0044});
        chk("s2_pulse", {48'h0, pb}, {48'h0, 16'h0004});

        // Step 3: read with r_ready held off
        axi_read(32'h04, 5, rdata, resp, lat, stable);
        chk("s3_rdata", {32'h0, rdata}, {32'h0, 32'hDEAD_BEEF});
        chk("s3_rresp", {62'h0, resp}, 64'h0);
        chk("s3_rlat", lat, 64'd0);
        chk("s3_stable", {63'h0, stable}, 64'h1);

        // Step 4: out-of-range and misaligned
        axi_read(32'h40, 0, rdata, resp, lat, stable);
        chk("s4_oor_resp", {62'h0, resp}, {62'h0, 2'b10});
        chk("s4_oor_data", {32'h0, rdata}, 64'h0);
        axi_read(32'h06, 1, rdata, resp, lat, stable);
        chk("s4_mis_resp", {62'h0, resp}, {62'h0, 2'b10});
        chk("s4_mis_data", {32'h0, rdata}, 64'h0);
        axi_write(32'h40, 32'h5555_AAAA, 4'hF, 0, 1, resp, lat, pb, pa, glitch, idle);
        chk("s4_wr_resp", {62'h0, resp}, {62'h0, 2'b10});
        chk("s4_wr_pulse", {48'h0, pb}, 64'h0);
        chk_ctrl("s4");

        // Step 5: read-only register 15
        axi_read(32'h3C, 0, rdata, resp, lat, stable);
        chk("s5_ro_data", {32'h0, rdata}, {32'h0, 32'h0000_CAFE});
        chk("s5_ro_resp", {62'h0, resp}, 64'h0);
        axi_write(32'h3C, 32'h1234_5678, 4'hF, 1, 0, resp, lat, pb, pa, glitch, idle);
        chk("s5_ro_wr_resp", {62'h0, resp}, {62'h0, 2'b10});
        chk("s5_ro_wr_pulse", {48'h0, pb}, 64'h0);
        chk_ctrl("s5");

        // Step 6: simultaneous read and write of reg 3
        bus.ar_addr = 32'h0C; bus.aw_addr = 32'h0C; bus.w_data = 32'h5; bus.w_strb = 4'hF;
        bus.ar_valid = 1'b1; bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        @(posedge clk); #1;
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        chk("s6_rvalid_bvalid", {62'h0, bus.r_valid, bus.b_valid}, {62'h0, 2'b11});
        chk("s6_rdata_old", {32'h0, bus.r_data}, {32'h0, mdl[3]});
        chk("s6_resps", {60'h0, bus.r_resp, bus.b_resp}, 64'h0);
        chk("s6_pulse", {48'h0, wr_pulse}, {48'h0, 16'h0008});
        mdl[3] = 32'h5;
        bus.r_ready = 1'b1; bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.r_ready = 1'b0; bus.b_ready = 1'b0;
        axi_read(32'h0C, 0, rdata, resp, lat, stable);
        chk("s6_rdata_new", {32'h0, rdata}, {32'h0, 32'h5});

        // Randomized traffic against the model
        status[15] = $urandom;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            idx = $urandom_range(0, 14);
            if (sel == 0) addr = 32'(idx * 4 + $urandom_range(1, 3));
            else if (sel == 1) addr = 32'(64 + 4 * $urandom_range(0, 63));
            else if (sel == 2) addr = 32'h3C;
            else addr = 32'(idx * 4);
            hit = (addr < 32'd64) && (addr[1:0] == 2'b00);
            idx = int'(addr >> 2) & 15;
            ro  = hit && (idx == 15);
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, data, strb, $urandom_range(0, 2), $urandom_range(0, 2),
                          resp, lat, pb, pa, glitch, idle);
                exp_pulse = (hit && !ro) ? (16'h1 << idx) : 16'h0;
                if (hit && !ro) mdl[idx] = merge(mdl[idx], data, strb);
                chk($sformatf("rnd%0d_bresp", n), {62'h0, resp}, {62'h0, (hit && !ro) ? 2'b00 : 2'b10});
                chk($sformatf("rnd%0d_blat", n), lat, 64'd0);
                chk($sformatf("rnd%0d_hold", n), {63'h0, glitch}, 64'h0);
                chk($sformatf("rnd%0d_pulse", n), {48'h0, pb, pa}, {32'h0, exp_pulse, 16'h0});
                chk($sformatf("rnd%0d_idle", n), {63'h0, idle}, 64'h1);
                chk_ctrl($sformatf("rnd%0d", n));
            end else begin
                axi_read(addr, $urandom_range(0, 3), rdata, resp, lat, stable);
                chk($sformatf("rnd%0d_rresp", n), {62'h0, resp}, {62'h0, hit ? 2'b00 : 2'b10});
                chk($sformatf("rnd%0d_rdata", n), {32'h0, rdata},
                    {32'h0, !hit ? 32'h0 : (ro ? status[15] : mdl[idx])});
                chk($sformatf("rnd%0d_rstable", n), {63'h0, stable}, 64'h1);
            end
        end

        // Reset while a write response is pending
        bus.aw_addr = 32'h10; bus.w_data = 32'hA5A5_5A5A; bus.w_strb = 4'hF;
        bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        @(posedge clk); #1;
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        chk("rst2_bvalid_before", {63'h0, bus.b_valid}, 64'h1);
        rstn = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) mdl[k] = 32'h0;
        chk("rst2_bvalid", {63'h0, bus.b_valid}, 64'h0);
        chk("rst2_ready", {61'h0, bus.ar_ready, bus.aw_ready, bus.w_ready}, {61'h0, 3'b111});
        chk("rst2_pulse", {48'h0, wr_pulse}, 64'h0);
        chk_ctrl("rst2");
        rstn = 1'b1;
        @(posedge clk); #1;
        axi_read(32'h10, 0, rdata, resp, lat, stable);
        chk("rst2_read", {30'h0, resp, rdata}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
